// File: rtl/audio_pkg.sv
// Codec audio constants shared by the I2S transmitter and the line-in receiver.
package audio_pkg;
   localparam int   XCK_PER_BCK_HALF = 6;
   localparam int   AUDIO_SAMPLE_W   = 16;
   localparam logic LRCK_LEFT        = 1'b0;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/i2s_clkgen.sv
// BCK/LRCK generator from XCK: registered clocks plus a bck_fall strobe and end-of-slot strobe.
// Strobes are combinational and valid in the XCK cycle whose closing edge drops BCK; no backpressure.
module i2s_clkgen
   import audio_pkg::*;
#(
   parameter int BCK_HALF = XCK_PER_BCK_HALF,
   parameter int SAMPLE_W = AUDIO_SAMPLE_W
) (
   input  logic clk,
   input  logic rst,
   output logic bck,
   output logic lrck,
   output logic bck_fall,
   output logic slot_end
);
   localparam int DIV_W = cnt_width(BCK_HALF);
   localparam int BIT_W = cnt_width(SAMPLE_W);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCK_HALF - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(SAMPLE_W - 1);

   logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             bck_q, bck_d;
   logic             lrck_q, lrck_d;
   logic             div_wrap;

   always_comb begin
      div_wrap  = (div_cnt_q == DIV_LAST);
      bck_fall  = div_wrap && bck_q;
      slot_end  = bck_fall && (bit_cnt_q == BIT_LAST);
      div_cnt_d = div_wrap ? '0 : div_cnt_q + 1'b1;
      bck_d     = div_wrap ? ~bck_q : bck_q;
      bit_cnt_d = bit_cnt_q;
      lrck_d    = lrck_q;
      // LRCK only ever changes together with a BCK fall.
      if (bck_fall) begin
         bit_cnt_d = slot_end ? '0 : bit_cnt_q + 1'b1;
         if (slot_end) lrck_d = ~lrck_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         bck_q     <= 1'b0;
         lrck_q    <= LRCK_LEFT;
      end else begin
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         bck_q     <= bck_d;
         lrck_q    <= lrck_d;
      end
   end

   assign bck  = bck_q;
   assign lrck = lrck_q;
endmodule

// File: rtl/i2s_audio_out.sv
// I2S DAC transmitter: stereo frames in over valid/ready, MSB-first serial out with the one-bit I2S delay.
// Latency up to ~1 frame + 1 BCK; one hold register, ready stays low from accept until the next frame load.
module i2s_audio_out
   import audio_pkg::*;
#(
   parameter int BCK_HALF = XCK_PER_BCK_HALF,
   parameter int SAMPLE_W = AUDIO_SAMPLE_W
) (
   input  logic                AUD_XCK,
   input  logic                reset,
   input  logic [SAMPLE_W-1:0] left_in,
   input  logic [SAMPLE_W-1:0] right_in,
   input  logic                sample_valid,
   output logic                sample_ready,
   output logic                AUD_BCK,
   output logic                AUD_DACLRCK,
   output logic                AUD_DACDAT,
   output logic                underrun
);
   logic                bck_fall, slot_end, lrck;
   logic [SAMPLE_W-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
   logic [SAMPLE_W-1:0] frame_l_q, frame_l_d, frame_r_q, frame_r_d;
   logic [SAMPLE_W-1:0] shift_q, shift_d;
   logic                hold_full_q, hold_full_d;
   logic                dacdat_q, dacdat_d;
   logic                underrun_q, underrun_d;

   i2s_clkgen #(.BCK_HALF(BCK_HALF), .SAMPLE_W(SAMPLE_W)) u_clkgen (
      .clk      (AUD_XCK),
      .rst      (reset),
      .bck      (AUD_BCK),
      .lrck     (lrck),
      .bck_fall (bck_fall),
      .slot_end (slot_end)
   );

   always_comb begin
      hold_l_d    = hold_l_q;
      hold_r_d    = hold_r_q;
      hold_full_d = hold_full_q;
      frame_l_d   = frame_l_q;
      frame_r_d   = frame_r_q;
      shift_d     = shift_q;
      dacdat_d    = dacdat_q;
      underrun_d  = 1'b0;
      // Top of shift reg is the next bit out; after 15 shifts it holds the LSB for the k=0 fall.
      if (bck_fall) begin
         dacdat_d = shift_q[SAMPLE_W-1];
         if (slot_end) begin
            if (lrck != LRCK_LEFT) begin
               if (hold_full_q) begin
                  frame_l_d   = hold_l_q;
                  frame_r_d   = hold_r_q;
                  hold_full_d = 1'b0;
               end else begin
                  frame_l_d  = '0;
                  frame_r_d  = '0;
                  underrun_d = 1'b1;
               end
               shift_d = frame_l_d;
            end else begin
               shift_d = frame_r_q;
            end
         end else begin
            shift_d = {shift_q[SAMPLE_W-2:0], 1'b0};
         end
      end
      // Accept is evaluated after the load so a same-cycle frame waits for the next load.
      if (sample_valid && !hold_full_q) begin
         hold_l_d    = left_in;
         hold_r_d    = right_in;
         hold_full_d = 1'b1;
      end
   end

   always_ff @(posedge AUD_XCK or posedge reset) begin
      if (reset) begin
         hold_l_q    <= '0;
         hold_r_q    <= '0;
         hold_full_q <= 1'b0;
         frame_l_q   <= '0;
         frame_r_q   <= '0;
         shift_q     <= '0;
         dacdat_q    <= 1'b0;
         underrun_q  <= 1'b0;
      end else begin
         hold_l_q    <= hold_l_d;
         hold_r_q    <= hold_r_d;
         hold_full_q <= hold_full_d;
         frame_l_q   <= frame_l_d;
         frame_r_q   <= frame_r_d;
         shift_q     <= shift_d;
         dacdat_q    <= dacdat_d;
         underrun_q  <= underrun_d;
      end
   end

   assign sample_ready = !hold_full_q;
   assign AUD_DACLRCK  = lrck;
   assign AUD_DACDAT   = dacdat_q;
   assign underrun     = underrun_q;
endmodule

// File: tb/tb_i2s_audio_out.sv
// Bench for i2s_audio_out: frame-level reference model feeding a scoreboard, I2S decoder on BCK rise.
module tb_i2s_audio_out;
   localparam int FRAME = 384;

   typedef struct { logic [15:0] l; logic [15:0] r; logic [15:0] exp_l; logic [15:0] exp_r; } vec_t;
   typedef struct packed { logic [15:0] l; logic [15:0] r; logic is_data; } exp_t;

   logic        AUD_XCK = 1'b0;
   logic        reset;
   logic [15:0] left_in, right_in;
   logic        sample_valid;
   logic        sample_ready, AUD_BCK, AUD_DACLRCK, AUD_DACDAT, underrun;

   i2s_audio_out dut (
      .AUD_XCK(AUD_XCK), .reset(reset), .left_in(left_in), .right_in(right_in),
      .sample_valid(sample_valid), .sample_ready(sample_ready), .AUD_BCK(AUD_BCK),
      .AUD_DACLRCK(AUD_DACLRCK), .AUD_DACDAT(AUD_DACDAT), .underrun(underrun)
   );

   always #5 AUD_XCK = ~AUD_XCK;

   int n_chk = 0, n_pass = 0;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference model: frame loads every FRAME XCK edges after release, one hold register.
   int          edge_n = 0, acc_cnt = 0, exp_data_cnt = 0, last_acc_edge = 0;
   logic        m_full = 1'b0, m_und = 1'b0, m_acc;
   logic [15:0] m_l = '0, m_r = '0, drv_el = '0, drv_er = '0;
   exp_t        exp_q[$];
   int          dec_data_cnt = 0;

   always @(posedge AUD_XCK or posedge reset) begin
      if (reset) begin
         edge_n = 0;
         m_full = 1'b0;
         m_und  = 1'b0;
         exp_q.delete();
         exp_q.push_back({16'h0, 16'h0, 1'b0});
         exp_data_cnt = dec_data_cnt;
      end else begin
         m_acc = sample_valid && !m_full;
         edge_n++;
         m_und = 1'b0;
         if (edge_n % FRAME == 0) begin
            if (m_full) begin
               exp_q.push_back({m_l, m_r, 1'b1});
               exp_data_cnt++;
               m_full = 1'b0;
            end else begin
               exp_q.push_back({16'h0, 16'h0, 1'b0});
               m_und = 1'b1;
            end
         end
         if (m_acc) begin
            m_l = drv_el; m_r = drv_er; m_full = 1'b1;
            acc_cnt++; last_acc_edge = edge_n;
         end
      end
   end

   // Monitor and decoder, sampled on the XCK falling edge.
   logic        bck_p = 1'b0, lr_p = 1'b0, dec_lr = 1'b0;
   logic [15:0] dec_sr = '0, dec_l = '0, word;
   int t = 0, last_rise = -1, last_lr_rise = -1, last_lr_fall = -1;
   int bck_bad = 0, lrck_bad = 0, und_pos_bad = 0, ready_bad = 0, und_bad = 0;
   int und_cnt = 0, lr_edges = 0, dat_ones = 0;
   exp_t e;

   always @(negedge AUD_XCK) begin
      if (reset) begin
         bck_p = 1'b0; lr_p = 1'b0; dec_lr = 1'b0; dec_sr = '0;
         t = 0; last_rise = -1; last_lr_rise = -1; last_lr_fall = -1;
      end else begin
         t++;
         if (sample_ready !== !m_full) ready_bad++;
         if (underrun !== m_und) und_bad++;
         if (underrun === 1'b1) begin
            und_cnt++;
            if (!(lr_p && !AUD_DACLRCK)) und_pos_bad++;
         end
         if (AUD_DACDAT === 1'b1) dat_ones++;
         if (AUD_BCK && !bck_p) begin
            if (last_rise >= 0 && t - last_rise != 12) bck_bad++;
            last_rise = t;
         end
         if (!AUD_BCK && bck_p && t - last_rise != 6) bck_bad++;
         if (AUD_DACLRCK != lr_p) begin
            lr_edges++;
            if (!(bck_p && !AUD_BCK)) lrck_bad++;
            if (AUD_DACLRCK) last_lr_rise = t;
            else begin
               if (t - last_lr_rise != FRAME / 2) lrck_bad++;
               if (last_lr_fall >= 0 && t - last_lr_fall != FRAME) lrck_bad++;
               last_lr_fall = t;
            end
         end
         if (AUD_BCK && !bck_p) begin
            word = {dec_sr[14:0], AUD_DACDAT};
            dec_sr = word;
            if (AUD_DACLRCK != dec_lr) begin
               if (!dec_lr) dec_l = word;
               else begin
                  check("sb_nonempty", exp_q.size() != 0, 1);
                  if (exp_q.size() != 0) begin
                     e = exp_q.pop_front();
                     check("dec_left", dec_l, e.l);
                     check("dec_right", word, e.r);
                     if (e.is_data) dec_data_cnt++;
                  end
               end
               dec_lr = AUD_DACLRCK;
            end
         end
         bck_p = AUD_BCK;
         lr_p  = AUD_DACLRCK;
      end
   end

   task automatic release_rst();
      int n_rise = 0, n_fall = 0;
      @(posedge AUD_XCK); #3; reset = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge AUD_XCK); #1;
         if (AUD_BCK && n_rise == 0) n_rise = i;
         if (!AUD_BCK && n_rise != 0 && n_fall == 0) n_fall = i;
      end
      check("first_bck_rise_edge", n_rise, 6);
      check("first_bck_fall_edge", n_fall, 12);
   endtask

   task automatic wait_edge_mod(input int m);
      bit hit = 0;
      for (int i = 0; i < 2 * FRAME && !hit; i++) begin
         @(posedge AUD_XCK); #1;
         if (edge_n % FRAME == m) hit = 1;
      end
      check("wait_edge_mod", hit, 1);
   endtask

   task automatic send(input logic [15:0] l, input logic [15:0] r, input logic [15:0] el,
                       input logic [15:0] er, input bit keep_valid);
      bit ok = 0;
      logic rdy;
      left_in = l; right_in = r; drv_el = el; drv_er = er; sample_valid = 1'b1;
      for (int i = 0; i < 3 * FRAME && !ok; i++) begin
         rdy = sample_ready;
         @(posedge AUD_XCK); #1;
         if (rdy) ok = 1;
      end
      if (!keep_valid) sample_valid = 1'b0;
      check("accept", ok, 1);
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 4 * FRAME && !ok; i++) begin
         @(posedge AUD_XCK); #1;
         ok = !m_full && (dec_data_cnt == exp_data_cnt);
      end
      check("drain", ok, 1);
   endtask

   initial begin
      vec_t vecs[6];
      int   u0, lr0, d0, a0, prev_edge, rises;
      logic bck_prev;
      vecs[0] = '{16'hA5C3, 16'h8001, 16'hA5C3, 16'h8001};
      vecs[1] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
      vecs[2] = '{16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF};
      vecs[3] = '{16'h1234, 16'hFEDC, 16'h1234, 16'hFEDC};
      vecs[4] = '{16'h0001, 16'h8000, 16'h0001, 16'h8000};
      vecs[5] = '{16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001};
      sample_valid = 1'b0; left_in = '0; right_in = '0;
      reset = 1'b1;

      // Reset state and first BCK edges after release.
      @(posedge AUD_XCK); #1;
      check("rst_bck", AUD_BCK, 0);
      check("rst_lrck", AUD_DACLRCK, 0);
      check("rst_dat", AUD_DACDAT, 0);
      check("rst_underrun", underrun, 0);
      check("rst_ready", sample_ready, 1);
      release_rst();

      // Idle free-run: clock shape, silence, one underrun per frame.
      wait_edge_mod(10);
      u0 = und_cnt; lr0 = lr_edges; d0 = dat_ones;
      repeat (4 * FRAME) @(posedge AUD_XCK);
      #1;
      check("idle_underruns", und_cnt - u0, 4);
      check("idle_lrck_edges", lr_edges - lr0, 8);
      check("idle_dat_ones", dat_ones - d0, 0);
      check("bck_timing", bck_bad, 0);
      check("lrck_timing", lrck_bad, 0);
      check("underrun_position", und_pos_bad, 0);

      // Table vectors; the first also checks MSB placement at the 2nd BCK rise.
      for (int i = 0; i < 6; i++) begin
         send(vecs[i].l, vecs[i].r, vecs[i].exp_l, vecs[i].exp_r, 1'b0);
         if (i == 0) begin
            wait_edge_mod(0);
            rises = 0; bck_prev = AUD_BCK;
            for (int c = 0; c < 40 && rises < 2; c++) begin
               @(posedge AUD_XCK); #1;
               if (AUD_BCK && !bck_prev) begin
                  rises++;
                  check(rises == 1 ? "rise1_prev_lsb" : "rise2_left_msb", AUD_DACDAT, rises == 1 ? 0 : 1);
               end
               bck_prev = AUD_BCK;
            end
            check("rise_count", rises, 2);
         end
      end
      drain();

      // Valid held high with counter data: one accept per frame, no underrun.
      wait_edge_mod(100);
      a0 = acc_cnt; u0 = 0; prev_edge = 0;
      for (int n = 0; n < 8; n++) begin
         send(16'(n), ~16'(n), 16'(n), ~16'(n), 1'b1);
         if (n == 0) u0 = und_cnt;
         else if (n >= 2) check("accept_spacing", last_acc_edge - prev_edge, FRAME);
         prev_edge = last_acc_edge;
      end
      sample_valid = 1'b0;
      check("stream_accepts", acc_cnt - a0, 8);
      check("stream_no_underrun", und_cnt - u0, 0);
      drain();

      // One-cycle valid exactly on the load cycle with hold empty.
      wait_edge_mod(FRAME - 1);
      left_in = 16'h1357; right_in = 16'hC0DE; drv_el = 16'h1357; drv_er = 16'hC0DE;
      sample_valid = 1'b1;
      @(posedge AUD_XCK); #1;
      sample_valid = 1'b0;
      check("load_accept_underrun", underrun, 1);
      check("load_accept_ready", sample_ready, 0);
      drain();

      // Reset mid right slot with a frame held: everything clears, held frame discarded.
      wait_edge_mod(250);
      send(16'hDEAD, 16'hBEEF, 16'hDEAD, 16'hBEEF, 1'b0);
      wait_edge_mod(290);
      check("mid_right_slot", AUD_DACLRCK, 1);
      check("held_ready", sample_ready, 0);
      #3 reset = 1'b1;
      #1;
      check("arst_bck", AUD_BCK, 0);
      check("arst_lrck", AUD_DACLRCK, 0);
      check("arst_dat", AUD_DACDAT, 0);
      check("arst_underrun", underrun, 0);
      check("arst_ready", sample_ready, 1);
      repeat (3) @(posedge AUD_XCK);
      #1;
      release_rst();
      u0 = und_cnt;
      repeat (2 * FRAME) @(posedge AUD_XCK);
      #1;
      check("post_reset_underruns", und_cnt - u0, 2);

      check("ready_tracking", ready_bad, 0);
      check("underrun_tracking", und_bad, 0);
      check("bck_timing_final", bck_bad, 0);
      check("lrck_timing_final", lrck_bad, 0);
      check("underrun_position_final", und_pos_bad, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
